// File: rtl/demux_5bit_dist_pkg.sv
// Shared widths, lane-select codes and lane-state encoding for the 1-to-4 5-bit distributor.
package demux_5bit_dist_pkg;

  localparam int DMX_W     = 5;
  localparam int DMX_NLANE = 4;
  localparam int DMX_CW    = 8;

  typedef enum logic [1:0] {
    LANE0 = 2'b00,
    LANE1 = 2'b01,
    LANE2 = 2'b10,
    LANE3 = 2'b11
  } lane_sel_e;

  typedef enum logic {
    LS_EMPTY = 1'b0,
    LS_FULL  = 1'b1
  } lane_state_e;

  function automatic logic [DMX_NLANE-1:0] sel_onehot(input logic [1:0] sel);
    logic [DMX_NLANE-1:0] oh;
    oh = '0;
    case (lane_sel_e'(sel))
      LANE0:   oh = 4'b0001;
      LANE1:   oh = 4'b0010;
      LANE2:   oh = 4'b0100;
      LANE3:   oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_5bit_dist_lane.sv
// One output lane: single-entry word buffer, EMPTY/FULL valid FSM and delivered-word counter.
module demux_5bit_dist_lane
  import demux_5bit_dist_pkg::*;
#(
  parameter int W  = DMX_W,
  parameter int CW = DMX_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [W-1:0]  din,
  input  logic          ready,
  output logic          valid,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] cnt
);

  lane_state_e   state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drain;

  assign drain = (state_q == LS_FULL) & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LS_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // The top only loads a FULL lane in a cycle where it also drains.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      LS_EMPTY: if (load)          state_d = LS_FULL;
      LS_FULL:  if (drain && !load) state_d = LS_EMPTY;
      default:                     state_d = LS_EMPTY;
    endcase
    if (load)  data_d = din;
    if (drain) cnt_d  = cnt_q + CW'(1);
  end

  always_comb begin
    valid = (state_q == LS_FULL);
    dout  = data_q;
    cnt   = cnt_q;
  end

endmodule

// File: rtl/demux_5bit_dist.sv
// Registered 1-to-4 distributor: steers one 5-bit stream into four buffered valid/ready lanes.
module demux_5bit_dist
  import demux_5bit_dist_pkg::*;
#(
  parameter int W     = DMX_W,
  parameter int NLANE = DMX_NLANE,
  parameter int CW    = DMX_CW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        in_data,
  input  logic [1:0]          in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NLANE*W-1:0]  out_data,
  output logic [NLANE-1:0]    out_valid,
  input  logic [NLANE-1:0]    out_ready,
  output logic [NLANE*CW-1:0] lane_cnt
);

  logic             acc;
  logic [NLANE-1:0] load;

  // Only the addressed lane can stall the input.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign acc      = in_valid & in_ready;
  assign load     = acc ? sel_onehot(in_sel) : '0;

  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    demux_5bit_dist_lane #(
      .W  (W),
      .CW (CW)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .din   (in_data),
      .ready (out_ready[k]),
      .valid (out_valid[k]),
      .dout  (out_data[k*W +: W]),
      .cnt   (lane_cnt[k*CW +: CW])
    );
  end

endmodule

// File: tb/tb_demux_5bit_dist.sv
// Scoreboard bench for demux_5bit_dist: per-lane expected-word queues, directed scenarios, random traffic.
module tb_demux_5bit_dist;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [31:0] lane_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: each lane is a queue of accepted-but-undelivered words.
  logic [4:0] exp_q [4][$];
  logic [4:0] exp_last [4] = '{default: '0};
  logic [7:0] exp_cnt  [4] = '{default: '0};

  demux_5bit_dist dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lane_cnt  (lane_cnt)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [4:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  always @(negedge rst_n) begin
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      exp_last[k] = '0;
      exp_cnt[k]  = '0;
    end
  end

  // Stimulus side: record each word the model says is accepted at this edge.
  always @(posedge clk) begin
    if (rst_n && in_valid) begin
      if ($isunknown(in_sel)) begin
        n_checks++;
        $display("FAIL in_sel_known: got %b with in_valid=1", in_sel);
      end else if (exp_q[in_sel].size() == 0) begin
        exp_q[in_sel].push_back(in_data);
        exp_last[in_sel] = in_data;
      end
    end
  end

  // Monitor: compare DUT outputs with the model mid-cycle, pop words being delivered.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", {31'd0, in_ready},
            {31'd0, (exp_q[in_sel].size() == 0) || out_ready[in_sel]});
      for (int k = 0; k < 4; k++) begin
        check($sformatf("valid%0d", k), {31'd0, out_valid[k]}, {31'd0, exp_q[k].size() != 0});
        check($sformatf("data%0d", k), {27'd0, out_data[k*5 +: 5]}, {27'd0, exp_last[k]});
        check($sformatf("cnt%0d", k), {24'd0, lane_cnt[k*8 +: 8]}, {24'd0, exp_cnt[k]});
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            check($sformatf("underflow%0d", k), 32'd1, 32'd0);
          end else begin
            check($sformatf("deliver%0d", k), {27'd0, out_data[k*5 +: 5]}, {27'd0, exp_q[k][0]});
            void'(exp_q[k].pop_front());
            exp_cnt[k] = exp_cnt[k] + 8'd1;
          end
        end
      end
    end
  end

  initial begin
    // Reset held with in_valid asserted
    drive(1'b1, 2'b00, 5'b10000, 4'b1111);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {28'd0, out_valid}, 32'd0);
    check("rst_data", {12'd0, out_data}, 32'd0);
    check("rst_cnt", lane_cnt, 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 5'b00000, 4'b1111);
    tick();

    // Steering
    drive(1'b1, 2'b00, 5'b10000, 4'b1111); tick();
    check("steer_v0", {28'd0, out_valid}, 32'b0001);
    check("steer_d0", {27'd0, out_data[4:0]}, 32'b10000);
    drive(1'b1, 2'b01, 5'b00010, 4'b1111); tick();
    check("steer_v1", {28'd0, out_valid}, 32'b0010);
    check("steer_d1", {27'd0, out_data[9:5]}, 32'b00010);
    drive(1'b1, 2'b10, 5'b00000, 4'b1111); tick();
    check("steer_v2", {28'd0, out_valid}, 32'b0100);
    drive(1'b1, 2'b11, 5'b01101, 4'b1111); tick();
    check("steer_v3", {28'd0, out_valid}, 32'b1000);
    check("steer_d3", {27'd0, out_data[19:15]}, 32'b01101);
    drive(1'b0, 2'b00, 5'b00000, 4'b1111); tick();
    check("steer_cnt", lane_cnt, 32'h01010101);

    // Backpressure on lane 2
    drive(1'b1, 2'b10, 5'b00000, 4'b1011); tick();
    drive(1'b1, 2'b10, 5'b10101, 4'b1011); #1;
    check("bp_ready_lo", {31'd0, in_ready}, 32'd0);
    tick();
    check("bp_hold_v", {31'd0, out_valid[2]}, 32'd1);
    check("bp_hold_d", {27'd0, out_data[14:10]}, 32'b00000);
    drive(1'b1, 2'b01, 5'b00111, 4'b1011); #1;
    check("bp_other_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_other_v", {31'd0, out_valid[1]}, 32'd1);
    drive(1'b1, 2'b10, 5'b10101, 4'b1111); #1;
    check("bp_release_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_release_d", {27'd0, out_data[14:10]}, 32'b10101);
    check("bp_release_cnt", {24'd0, lane_cnt[23:16]}, 32'd2);
    drive(1'b0, 2'b00, 5'b00000, 4'b1111); tick();

    // Same-cycle drain and load on lane 0
    drive(1'b1, 2'b00, 5'b10000, 4'b0000); tick();
    drive(1'b1, 2'b00, 5'b11111, 4'b0001); tick();
    check("dl_valid", {31'd0, out_valid[0]}, 32'd1);
    check("dl_data", {27'd0, out_data[4:0]}, 32'b11111);
    check("dl_cnt", {24'd0, lane_cnt[7:0]}, 32'd2);
    drive(1'b0, 2'b00, 5'b00000, 4'b1111); tick();

    // Counter wrap on lane 3 (starts at 1)
    for (int i = 0; i < 254; i++) begin
      drive(1'b1, 2'b11, 5'($urandom), 4'b1111); tick();
    end
    drive(1'b0, 2'b00, 5'b00000, 4'b1111); tick();
    check("wrap_255", {24'd0, lane_cnt[31:24]}, 32'd255);
    drive(1'b1, 2'b11, 5'b01101, 4'b1111); tick();
    drive(1'b0, 2'b00, 5'b00000, 4'b1111); tick();
    check("wrap_0", {24'd0, lane_cnt[31:24]}, 32'd0);
    drive(1'b1, 2'b11, 5'b10000, 4'b1111); tick();
    drive(1'b0, 2'b00, 5'b00000, 4'b1111); tick();
    check("wrap_1", {24'd0, lane_cnt[31:24]}, 32'd1);

    // Async reset between edges with lanes 1 and 3 full
    drive(1'b1, 2'b01, 5'b01101, 4'b0000); tick();
    drive(1'b1, 2'b11, 5'b10000, 4'b0000); tick();
    drive(1'b0, 2'b00, 5'b00000, 4'b0000);
    check("ar_pre_v", {28'd0, out_valid}, 32'b1010);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", {28'd0, out_valid}, 32'd0);
    check("ar_data", {12'd0, out_data}, 32'd0);
    check("ar_cnt", lane_cnt, 32'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 2'b01, 5'b00010, 4'b0010); tick();
    check("ar_after_v", {28'd0, out_valid}, 32'b0010);
    check("ar_after_d", {27'd0, out_data[9:5]}, 32'b00010);
    drive(1'b0, 2'b00, 5'b00000, 4'b0010); tick();
    check("ar_after_cnt", lane_cnt, 32'h00000100);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 3) != 0), 2'($urandom), 5'($urandom), 4'($urandom));
      tick();
    end
    drive(1'b0, 2'b00, 5'b00000, 4'b1111);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
